// File: rtl/vga_ctrl_pkg.sv
// vga_ctrl_pkg -- shared defines for the VGA display path.
// Holds the default 640x480@60 timing constants, the image-memory (IM_*)
// geometry that the pixel_x/pixel_y address feeds, the counter width, and a
// small window-compare helper used for the sync pulses.
package vga_ctrl_pkg;

    // Pixel clock divider: 100 MHz system clock -> 25 MHz pixel rate.
    localparam int CLK_DIV_D  = 4;

    // Horizontal timing, in pixels.
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800

    // Vertical timing, in lines.
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525

    // Image memory geometry; one 12-bit {R,G,B} word per active pixel.
    localparam int IM_W       = H_ACTIVE_D;
    localparam int IM_H       = V_ACTIVE_D;
    localparam int IM_DATA_W  = 12;
    localparam int IM_DEPTH   = IM_W * IM_H;
    localparam int IM_ADDR_W  = $clog2(IM_DEPTH);

    // Width of h/v counters and of the pixel_x/pixel_y ports.
    localparam int CNT_W      = 10;

    // True when lo <= v <= hi (inclusive window).
    function automatic logic in_win(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_cnt.sv
// vga_cnt -- modulo-N counter with enable, used for both the horizontal
// (pixel) and vertical (line) position counters.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears cnt)
//   en        : advance by one this clk
//   cnt       : current count, 0..N-1
//   cnt_nxt   : value cnt takes at the next edge (lets the parent register
//               things that must change in the same clk as cnt)
//   wrap      : high when en is set and cnt is at N-1 (wraps to 0 next edge)
module vga_cnt #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (en)
            cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl -- VGA timing generator and pixel output stage.
// Divides the system clock down to a pixel strobe, walks the h/v raster,
// addresses an image memory with pixel_x/pixel_y and presents the returned
// colour one pixel later, blanked outside the visible area.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   pixel_x, pixel_y   : active column/row to image memory (0 when blanked)
//   rgb_in             : {R,G,B} from image memory, one-clk read latency
//   vga_r/g/b          : display colour, 4 bits each
//   hsync, vsync       : sync pulses, active low
//   video_on           : high while vga_r/g/b carry an active pixel
//   frame_start        : one-clk pulse after the raster wraps to (0,0)
module vga_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_D,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    input  logic [11:0]      rgb_in,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_L = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_L = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             active, active_nxt;

    // Pixel strobe: one clk in every CLK_DIV, on the last divider count, so
    // the first strobe lands CLK_DIV clks after reset release.
    assign pix_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || pix_en)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    vga_cnt #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap)
    );

    // Lines advance on the last pixel of each line.
    vga_cnt #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (h_wrap),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap)
    );

    assign active     = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    assign active_nxt = (h_nxt < H_ACT_L) && (v_nxt < V_ACT_L);

    // pixel_x/y are built from the counters' next values so the address
    // changes in the same clk as h_cnt/v_cnt. The colour stage works off the
    // current counters, i.e. one pixel behind the address, which gives the
    // image memory CLK_DIV-1 clks to return rgb_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // v_wrap already implies pix_en and h_wrap.
            frame_start <= v_wrap;
            if (pix_en) begin
                pixel_x  <= active_nxt ? h_nxt : '0;
                pixel_y  <= active_nxt ? v_nxt : '0;
                video_on <= active;
                {vga_r, vga_g, vga_b} <= active ? rgb_in : 12'h000;
                hsync    <= !in_win(h_cnt, HS_LO, HS_HI);
                vsync    <= !in_win(v_cnt, VS_LO, VS_HI);
            end
        end
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl -- directed bench for vga_ctrl on a shrunken raster so whole
// frames fit in a short run:
//   CLK_DIV=2, H: 8 active + 2 FP + 3 sync + 2 BP = 15 pixels/line
//              V: 6 active + 1 FP + 2 sync + 1 BP = 10 lines/frame
//   -> 30 clks per line, 300 clks per frame, hsync low h=10..12, vsync low v=7..8.
// Cycle k counts edges after reset release; outputs are sampled 1 time unit
// after each edge. Pixel strobes fall on even k; after edge k the counters
// have advanced k/2 pixels and the colour stage shows the pixel before that.
module tb_vga_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] rgb_in = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, video_on, frame_start;
    logic        rgb_force = 1'b0;

    vga_ctrl #(
        .CLK_DIV(2),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .rgb_in(rgb_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Image memory model: one-clk read latency.
    always @(posedge clk)
        rgb_in <= rgb_force ? 12'hFFF : {pixel_x[3:0], pixel_y[3:0], 4'hA};

    typedef struct {
        int         cyc;
        logic [9:0] px, py;
        logic       vo;
        logic [11:0] rgb;
        logic       hs, vs, fs;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0, n_err = 0;
    int   cyc;
    int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_t[$];
    int   max_px, max_py;
    logic prev_hs, prev_vs;

    function automatic vec_t mk(int c, int px, int py, logic vo, logic [11:0] rgb,
                                logic hs, logic vs, logic fs);
        vec_t v;
        v.cyc = c; v.px = 10'(px); v.py = 10'(py); v.vo = vo; v.rgb = rgb;
        v.hs = hs; v.vs = vs; v.fs = fs;
        return v;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_hist();
        cyc = 0;
        hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
        fs_t.delete();
        max_px = 0; max_py = 0;
        prev_hs = hsync; prev_vs = vsync;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (prev_hs && !hsync) hs_fall.push_back(cyc);
        if (!prev_hs && hsync) hs_rise.push_back(cyc);
        if (prev_vs && !vsync) vs_fall.push_back(cyc);
        if (!prev_vs && vsync) vs_rise.push_back(cyc);
        if (frame_start) fs_t.push_back(cyc);
        if (int'(pixel_x) > max_px) max_px = int'(pixel_x);
        if (int'(pixel_y) > max_py) max_py = int'(pixel_y);
        prev_hs = hsync; prev_vs = vsync;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pixel_x"},     int'(pixel_x), 0);
        check({tag, " pixel_y"},     int'(pixel_y), 0);
        check({tag, " rgb"},         int'({vga_r, vga_g, vga_b}), 0);
        check({tag, " video_on"},    int'(video_on), 0);
        check({tag, " hsync"},       int'(hsync), 1);
        check({tag, " vsync"},       int'(vsync), 1);
        check({tag, " frame_start"}, int'(frame_start), 0);
    endtask

    initial begin
        int first_pe, cnt, bad, guard;

        //           cyc  px py vo rgb     hs vs fs
        tbl.push_back(mk(  0, 0, 0, 0, 12'h000, 1, 1, 0));  // reset state
        tbl.push_back(mk(  1, 0, 0, 0, 12'h000, 1, 1, 0));  // divider not yet wrapped
        tbl.push_back(mk(  2, 1, 0, 1, 12'h00A, 1, 1, 0));  // first strobe, pixel (0,0)
        tbl.push_back(mk( 99, 4, 3, 1, 12'h33A, 1, 1, 0));
        tbl.push_back(mk(100, 5, 3, 1, 12'h43A, 1, 1, 0));  // address (5,3)
        tbl.push_back(mk(102, 6, 3, 1, 12'h53A, 1, 1, 0));  // colour of (5,3) one pixel later
        tbl.push_back(mk(112, 0, 0, 0, 12'h000, 0, 1, 0));  // h=10: blank, hsync starts
        tbl.push_back(mk(116, 0, 0, 0, 12'h000, 0, 1, 0));  // h=12: last hsync pixel
        tbl.push_back(mk(118, 0, 0, 0, 12'h000, 1, 1, 0));  // h=13: hsync released
        tbl.push_back(mk(166, 0, 0, 1, 12'h75A, 1, 1, 0));  // last active pixel (7,5)
        tbl.push_back(mk(212, 0, 0, 0, 12'h000, 1, 0, 0));  // v=7: vsync starts
        tbl.push_back(mk(270, 0, 0, 0, 12'h000, 1, 0, 0));  // (14,8): still in vsync
        tbl.push_back(mk(272, 0, 0, 0, 12'h000, 1, 1, 0));  // v=9: vsync released
        tbl.push_back(mk(299, 0, 0, 0, 12'h000, 1, 1, 0));
        tbl.push_back(mk(300, 0, 0, 0, 12'h000, 1, 1, 1));  // wrap -> frame_start
        tbl.push_back(mk(301, 0, 0, 0, 12'h000, 1, 1, 0));  // one clk wide
        tbl.push_back(mk(302, 1, 0, 1, 12'h00A, 1, 1, 0));  // frame 2 pixel (0,0)

        // ---- Phase A: vectors from reset release, plus sync/frame timing.
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        clear_hist();
        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc < tbl[i].cyc) tick();
            check($sformatf("v%0d pixel_x", tbl[i].cyc), int'(pixel_x), int'(tbl[i].px));
            check($sformatf("v%0d pixel_y", tbl[i].cyc), int'(pixel_y), int'(tbl[i].py));
            check($sformatf("v%0d video_on", tbl[i].cyc), int'(video_on), int'(tbl[i].vo));
            check($sformatf("v%0d rgb", tbl[i].cyc), int'({vga_r, vga_g, vga_b}), int'(tbl[i].rgb));
            check($sformatf("v%0d hsync", tbl[i].cyc), int'(hsync), int'(tbl[i].hs));
            check($sformatf("v%0d vsync", tbl[i].cyc), int'(vsync), int'(tbl[i].vs));
            check($sformatf("v%0d frame_start", tbl[i].cyc), int'(frame_start), int'(tbl[i].fs));
        end
        while (cyc < 620) tick();

        check("hsync first fall",  qget(hs_fall, 0), 22);
        check("hsync period",      qget(hs_fall, 1) - qget(hs_fall, 0), 30);
        check("hsync low width",   qget(hs_rise, 0) - qget(hs_fall, 0), 6);
        check("vsync first fall",  qget(vs_fall, 0), 212);
        check("vsync period",      qget(vs_fall, 1) - qget(vs_fall, 0), 300);
        check("vsync low width",   qget(vs_rise, 0) - qget(vs_fall, 0), 60);
        check("frame_start count", fs_t.size(), 2);
        check("frame_start first", qget(fs_t, 0), 300);
        check("frame_start gap",   qget(fs_t, 1) - qget(fs_t, 0), 300);
        check("pixel_x max",       max_px, 7);
        check("pixel_y max",       max_py, 5);

        // ---- Phase B: reset mid-frame at (4,3).
        guard = 0;
        while (!(pixel_x == 10'd4 && pixel_y == 10'd3) && guard < 400) begin
            tick(); guard++;
        end
        check("reach (4,3) in time", int'(guard < 400), 1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;
        clear_hist();
        check("post-release pixel_x", int'(pixel_x), 0);
        check("post-release pixel_y", int'(pixel_y), 0);
        first_pe = -1;
        while (cyc < 299) begin
            tick();
            if (first_pe < 0 && pixel_x == 10'd1) first_pe = cyc;
        end
        check("first strobe after release", first_pe, 2);
        check("hsync fall after first strobe", qget(hs_fall, 0) - first_pe, 20);
        check("no frame_start for aborted frame", fs_t.size(), 0);
        tick();
        check("restarted frame_start", int'(frame_start), 1);

        // ---- Phase C: constant white input, count lit clks over one frame.
        rgb_force = 1'b1;
        guard = 0;
        while (!frame_start && guard < 400) begin tick(); guard++; end
        check("find frame_start", int'(guard < 400), 1);
        cnt = 0; bad = 0; guard = 0;
        do begin
            if ({vga_r, vga_g, vga_b} != 12'h000) cnt++;
            if (video_on ? ({vga_r, vga_g, vga_b} != 12'hFFF)
                         : ({vga_r, vga_g, vga_b} != 12'h000)) bad++;
            tick(); guard++;
        end while (!frame_start && guard < 400);
        check("white frame length", guard, 300);
        check("lit clks per frame", cnt, 6 * 8 * 2);
        check("colour vs video_on", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels (H_TOTAL 800).
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines (V_TOTAL 525).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 Ports: clk  in  1  system clock.
REQ-006 Ports: rst  in  1  synchronous active-high reset.
REQ-007 Ports: pixel_x  out  10  current active column, to image memory.
REQ-008 Ports: pixel_y  out  10  current active row, to image memory.
REQ-009 Ports: rgb_in  in  12  pixel colour {R,G,B} from image memory, one-clk read latency.
REQ-010 Ports: vga_r, vga_g, vga_b  out  4 each  display colour.
REQ-011 Ports: hsync, vsync  out  1  sync signals, active low.
REQ-012 Ports: video_on  out  1  high while vga_r/g/b carry an active pixel.
REQ-013 Ports: frame_start  out  1  one-clk pulse at the start of each frame.

Function
REQ-014 div_cnt SHALL count 0..CLK_DIV-1 and wrap; pix_en is high for exactly one clk when div_cnt==CLK_DIV-1.
REQ-015 On pix_en, h_cnt SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-016 On pix_en with h_cnt==H_TOTAL-1, v_cnt SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-017 Define active = (h_cnt<H_ACTIVE) and (v_cnt<V_ACTIVE).
REQ-018 pixel_x and pixel_y SHALL be registered; they update in the same clk as h_cnt and v_cnt.
REQ-019 pixel_x SHALL equal h_cnt and pixel_y SHALL equal v_cnt while active; otherwise both SHALL be 0.
REQ-020 Output stage, updated only on pix_en (one pixel after the counters, so rgb_in has had CLK_DIV-1 clks to settle):
- video_on <= active.
- {vga_r,vga_g,vga_b} <= active ? rgb_in : 0.
- hsync <= 0 iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default).
- vsync <= 0 iff v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default).
REQ-021 frame_start SHALL be high for exactly one clk: the clk after the pix_en on which the counters wrap from (799,524) to (0,0).
REQ-022 Blanking: outside the active region the colour outputs SHALL be 0 regardless of rgb_in.
REQ-023 All outputs SHALL be registered, with no combinational path from rgb_in to any output.
REQ-024 The hsync low period SHALL be exactly H_SYNC*CLK_DIV clks; the vsync low period SHALL be exactly V_SYNC*H_TOTAL*CLK_DIV clks.

Reset
REQ-025 While rst is high, the following SHALL be 0: div_cnt, h_cnt, v_cnt, pixel_x, pixel_y, colour outputs, video_on, frame_start.
REQ-026 While rst is high, hsync and vsync SHALL be 1 (inactive).
REQ-027 Reset asserted mid-frame SHALL take effect on the next clk edge; after release, the counters SHALL restart from (0,0) without a frame_start pulse for the aborted frame.
REQ-028 The first pix_en after reset release SHALL occur CLK_DIV clks after release.

Structure
REQ-029 The default timing constants (H_* and V_* totals and widths) SHALL live in the shared defines header alongside the IM_* image-memory constants.
REQ-030 One sub-module, vga_cnt, SHALL be used twice, for the horizontal and vertical counters: a parameterised modulo-N counter with enable and a wrap output.
REQ-031 pix_en generation and the output stage SHALL remain in vga_ctrl.

Verification
REQ-032 Release reset, then count clks between hsync falling edges -> 3200 (800*4); low width 384 clks.
REQ-033 Count clks between vsync falling edges -> 1,680,000 (525*800*4); low width 6400 clks.
REQ-034 Drive rgb_in = {pixel_x[3:0], pixel_y[3:0], 4'hA} combinationally with a one-clk delay.
- At (x=5, y=3) -> video_on=1 and RGB=0x53A, one pixel later.
- At h_cnt=700 -> RGB=0x000 and video_on=0.
REQ-035 Run two full frames -> exactly two frame_start pulses, each one clk wide, 1,680,000 clks apart; pixel_x maxes at 639 and pixel_y maxes at 479.
REQ-036 Assert rst for 2 clks at (x=320, y=240) -> next clk all outputs at reset values.
- After release: pixel_x=0 and pixel_y=0.
- First hsync fall 2624 clks ((656*4)) after the first pix_en.
REQ-037 Force rgb_in=0xFFF constantly -> colour is nonzero only on 640*480 pixels per frame (307,200 pix_en cycles with video_on=1).
